// File: rtl/barrel_shifter_r.sv
`default_nettype none
// ============================================================================
// Module   : barrel_shifter_r
// Purpose  : Log2(WIDTH)-stage mux-network barrel shifter with a registered
//            result (one cycle of latency). It supports logical left shift,
//            logical right shift and arithmetic right shift. Builds that
//            define BARREL_ROTATE_EN also support rotation.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            in_valid   - qualifies in/shift_mag/dir/arith/rot
//            in         - WIDTH-bit operand
//            shift_mag  - unsigned shift amount, 0..WIDTH-1
//            dir        - 0 = left, 1 = right
//            arith      - right shifts only: 1 = sign-fill, 0 = zero-fill
//            rot        - 1 = rotate (BARREL_ROTATE_EN builds only)
//            out        - registered result; holds when in_valid = 0
//            out_valid  - registered copy of in_valid
// Config   : `define BARREL_ROTATE_EN enables rotate. Without it, rot is
//            ignored.
// Revision : 1.0 - initial release
// ============================================================================
module barrel_shifter_r #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shift_mag,
    input  logic             dir,
    input  logic             arith,
    input  logic             rot,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic             w_rot;
    logic             w_fill;
    logic [WIDTH-1:0] w_rev_in;
    logic [WIDTH-1:0] w_net_in;
    logic [WIDTH-1:0] w_rev_net;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_stage [SHW+1];
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;

`ifdef BARREL_ROTATE_EN
    assign w_rot = rot;
`else
    // Rotation is not built. rot is intentionally dropped here.
    logic w_unused_rot;
    assign w_unused_rot = rot;
    assign w_rot        = 1'b0;
`endif

    // Only a non-rotating right shift can inject sign bits.
    // Left shifts and rotates never inject the sign bit.
    assign w_fill = dir & arith & ~w_rot & in[WIDTH-1];

    // The network only shifts right. For a left shift, the operand is
    // bit-reversed before the network and the result is reversed back
    // after it. A right shift/rotate of the reversed word is the left
    // shift/rotate of the original word.
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign w_rev_in[i]  = in[WIDTH-1-i];
        assign w_rev_net[i] = w_stage[SHW][WIDTH-1-i];
    end

    assign w_net_in   = dir ? in : w_rev_in;
    assign w_stage[0] = w_net_in;

    // Stage k moves every bit down by 2^k when shift_mag[k] is set.
    // Bit positions past the top either wrap (rotate) or take the fill bit.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int c_step = 1 << k;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i + c_step < WIDTH) begin : g_inner
                assign w_stage[k+1][i] = shift_mag[k] ? w_stage[k][i+c_step]
                                                      : w_stage[k][i];
            end else begin : g_edge
                assign w_stage[k+1][i] = shift_mag[k]
                    ? (w_rot ? w_stage[k][i+c_step-WIDTH] : w_fill)
                    : w_stage[k][i];
            end
        end
    end

    assign w_result = dir ? w_stage[SHW] : w_rev_net;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out <= w_result;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter_r.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrel_shifter_r
// Purpose  : Self-checking bench for barrel_shifter_r (WIDTH = 8). Expected
//            results are queued when stimulus is applied and popped when the
//            registered result appears.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_shifter_r;

    localparam int W = 8;
`ifdef BARREL_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] din;
    logic [2:0]   shift_mag;
    logic         dir;
    logic         arith;
    logic         rot;
    logic [W-1:0] dout;
    logic         out_valid;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_out;
    logic [W-1:0] exp_v;
    int           n_cmp;
    int           n_err;

    barrel_shifter_r #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (din),
        .shift_mag (shift_mag),
        .dir       (dir),
        .arith     (arith),
        .rot       (rot),
        .out       (dout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. It uses plain operators, not a mux network.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input int m,
                                           input logic d, input logic ar,
                                           input logic r);
        logic [W-1:0] res;
        if (ROT_EN && r) begin
            if (!d) res = (a << m) | (a >> (W - m));
            else    res = (a >> m) | (a << (W - m));
        end else if (!d) begin
            res = a << m;
        end else if (ar) begin
            res = $signed(a) >>> m;
        end else begin
            res = a >> m;
        end
        return res;
    endfunction

    // Drive one cycle of stimulus. Queue the expectation, then step past the
    // edge to the sampling point.
    task automatic apply(input logic v, input logic [W-1:0] a, input int m,
                         input logic d, input logic ar, input logic r);
        in_valid  = v;
        din       = a;
        shift_mag = 3'(m);
        dir       = d;
        arith     = ar;
        rot       = r;
        if (v) exp_q.push_back(model(a, m, d, ar, r));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        apply(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        n_cmp++;
        if (dout !== 8'h00) begin
            n_err++;
            $display("FAIL reset_out: got %h expected 00", dout);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        #3 rst_n = 1'b1;
        apply(1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || dout !== exp_v || dout !== 8'h00) begin
            n_err++;
            $display("FAIL first_result: got v=%b %h expected v=1 00", out_valid, dout);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] a_tab [7] = '{8'h10, 8'h04, 8'h80, 8'h80, 8'h81, 8'h81, 8'h81};
        int           m_tab [7] = '{1, 2, 3, 3, 1, 1, 1};
        logic         d_tab [7] = '{0, 0, 1, 1, 0, 1, 0};
        logic         ar_tab[7] = '{0, 0, 1, 0, 0, 0, 1};
        logic         r_tab [7] = '{0, 0, 0, 0, 1, 1, 0};
        logic [W-1:0] want  [7];
        want = '{8'h20, 8'h10, 8'hF0, 8'h10,
                 ROT_EN ? 8'h03 : 8'h02, ROT_EN ? 8'hC0 : 8'h40, 8'h02};
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, a_tab[i], m_tab[i], d_tab[i], ar_tab[i], r_tab[i]);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || dout !== exp_v || exp_v !== want[i]) begin
                n_err++;
                $display("FAIL directed[%0d]: got v=%b %h expected v=1 %h", i, out_valid, dout, want[i]);
            end
        end
    endtask

    task automatic test_zero_mag;
        for (int mode = 0; mode < 8; mode++) begin
            apply(1'b1, 8'hA5, 0, mode[0], mode[1], mode[2]);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (dout !== 8'hA5 || exp_v !== 8'hA5) begin
                n_err++;
                $display("FAIL zero_mag[%0d]: got %h expected a5", mode, dout);
            end
        end
    endtask

    task automatic test_hold;
        apply(1'b1, 8'hFF, 7, 1'b0, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (dout !== exp_v || exp_v !== 8'h80) begin
            n_err++;
            $display("FAIL max_left: got %h expected 80", dout);
        end
        apply(1'b0, 8'h3C, 2, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || dout !== 8'h80) begin
            n_err++;
            $display("FAIL hold: got v=%b %h expected v=0 80", out_valid, dout);
        end
    endtask

    task automatic test_back_to_back;
        logic v;
        last_out = dout;
        for (int i = 0; i < 48; i++) begin
            v = ($urandom_range(3) != 0);
            apply(v, 8'($urandom), int'($urandom_range(7)), 1'($urandom),
                  1'($urandom), 1'($urandom));
            if (v) begin
                exp_v    = exp_q.pop_front();
                last_out = exp_v;
            end
            n_cmp++;
            if (out_valid !== v || dout !== last_out) begin
                n_err++;
                $display("FAIL b2b[%0d]: got v=%b %h expected v=%b %h", i, out_valid, dout, v, last_out);
            end
        end
    endtask

    task automatic test_async_reset;
        apply(1'b1, 8'h10, 1, 1'b0, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (dout !== 8'h20) begin
            n_err++;
            $display("FAIL pre_reset: got %h expected 20", dout);
        end
        // Queue one more operand, then pull reset before its edge.
        in_valid = 1'b1;
        din      = 8'h55;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dout !== 8'h00 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b %h expected v=0 00", out_valid, dout);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (dout !== 8'h00 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held: got v=%b %h expected v=0 00", out_valid, dout);
        end
        exp_q.delete();
        #3 rst_n = 1'b1;
        apply(1'b0, 8'h77, 1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dout !== 8'h00 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_release_idle: got v=%b %h expected v=0 00", out_valid, dout);
        end
        apply(1'b1, 8'h81, 2, 1'b1, 1'b1, 1'b0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || dout !== exp_v || exp_v !== 8'hE0) begin
            n_err++;
            $display("FAIL post_release_first: got v=%b %h expected v=1 e0", out_valid, dout);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        din       = '0;
        shift_mag = '0;
        dir       = 1'b0;
        arith     = 1'b0;
        rot       = 1'b0;
        test_reset();
        test_directed();
        test_zero_mag();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
